// File: rtl/salu_instr_pkg.sv
// ----------------------------------------------------------------------------
// salu_instr_pkg
//  Shared scalar-ALU instruction encoding constants used by the instruction
//  buffer and its length decoder.
//   - ENC_*       : opcode-field match values for the scalar encodings
//   - LITERAL_SRC : source-operand code that means "32-bit literal follows"
//   - INSTR_SIZE  : widest instruction in bits (two dwords)
//   - instr_len_t : instruction length in dwords (LEN_1DW / LEN_2DW)
// ----------------------------------------------------------------------------
package salu_instr_pkg;

    localparam int INSTR_SIZE = 64;

    // Match values, compared against the top bits of the first dword.
    localparam logic [5:0] ENC_SMEM = 6'b111101;     // h[31:26]
    localparam logic [8:0] ENC_SOP1 = 9'b101111101;  // h[31:23]
    localparam logic [8:0] ENC_SOPC = 9'b101111110;  // h[31:23]
    localparam logic [8:0] ENC_SOPP = 9'b101111111;  // h[31:23]
    localparam logic [3:0] ENC_SOPK = 4'b1011;       // h[31:28]
    localparam logic [1:0] ENC_SOP2 = 2'b10;         // h[31:30]

    localparam logic [7:0] LITERAL_SRC = 8'd255;

    typedef enum logic {
        LEN_1DW = 1'b0,
        LEN_2DW = 1'b1
    } instr_len_t;

endpackage

// File: rtl/instr_len_decode.sv
// ----------------------------------------------------------------------------
// instr_len_decode
//  Purely combinational: looks at the first dword of an instruction and says
//  whether the instruction occupies one or two dwords.
//  Ports:
//   dword  in  32           first dword of the instruction
//   len    out instr_len_t  LEN_2DW for SMEM or a literal-carrying SOP1/SOP2/SOPC
// ----------------------------------------------------------------------------
module instr_len_decode
    import salu_instr_pkg::*;
(
    input  logic [31:0] dword,
    output instr_len_t  len
);

    logic is_smem;
    logic is_sop1;
    logic is_sopc;
    logic is_sopp;
    logic is_sopk;
    logic is_sop2;
    logic src0_lit;
    logic src1_lit;

    always_comb begin
        is_smem  = (dword[31:26] == ENC_SMEM);
        is_sop1  = (dword[31:23] == ENC_SOP1);
        is_sopc  = (dword[31:23] == ENC_SOPC);
        is_sopp  = (dword[31:23] == ENC_SOPP);
        // SOP1/SOPC/SOPP share the 1011 prefix with SOPK, so carve them out.
        is_sopk  = (dword[31:28] == ENC_SOPK) && !(is_sop1 || is_sopc || is_sopp);
        is_sop2  = (dword[31:30] == ENC_SOP2) && !(is_sopk || is_sop1 || is_sopc || is_sopp);
        src0_lit = (dword[7:0]  == LITERAL_SRC);
        src1_lit = (dword[15:8] == LITERAL_SRC);

        len = LEN_1DW;
        if (is_smem)
            len = LEN_2DW;
        else if ((is_sop2 || is_sopc) && (src0_lit || src1_lit))
            len = LEN_2DW;
        else if (is_sop1 && src0_lit)
            len = LEN_2DW;
    end

endmodule

// File: rtl/instr_dword_buffer.sv
// ----------------------------------------------------------------------------
// instr_dword_buffer
//  Dword FIFO between instruction fetch and the wavefront decoder. Dwords are
//  stored in program order; the head instruction (one or two dwords) is shown
//  combinationally to the decoder together with its byte PC.
//
//  Optional feature macro: INSTR_BUF_PERF_EN adds the stall_cycles counter.
//
//  Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch dword handshake, in_data = dword
//   out_valid/out_ready decoder handshake, out_data = instruction, out_pc = its PC
//   flush, flush_pc     drop everything, restart at flush_pc (dword aligned)
//   stall_cycles        (INSTR_BUF_PERF_EN) cycles with out_valid && !out_ready
//
//  Handshake: a transfer happens on a rising edge where valid && ready are both
//  high. ready never depends on valid on the same side; out_data/out_pc are a
//  function of stored state only, so they hold while out_valid && !out_ready.
// ----------------------------------------------------------------------------
module instr_dword_buffer
    import salu_instr_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWORD_W = 32,
    parameter int INSTR_W = INSTR_SIZE,
    parameter int PC_W    = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWORD_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_data,
    output logic [PC_W-1:0]    out_pc,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc
`ifdef INSTR_BUF_PERF_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DWORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    logic [PW-1:0]      nxt_ptr;
    logic [DWORD_W-1:0] head_dw;
    logic [DWORD_W-1:0] next_dw;
    instr_len_t         head_len;
    logic [CW-1:0]      len_dw;
    logic               push;
    logic               pop;

    instr_len_decode u_len_decode (
        .dword (head_dw),
        .len   (head_len)
    );

    always_comb begin
        // The second dword of a 64-bit instruction may sit past the wrap
        // point; the pointer width makes the +1 wrap for free.
        nxt_ptr   = rd_ptr + PW'(1);
        head_dw   = mem[rd_ptr];
        next_dw   = mem[nxt_ptr];
        len_dw    = (head_len == LEN_2DW) ? CW'(2) : CW'(1);
        out_valid = (count >= len_dw);
        out_data  = (head_len == LEN_2DW) ? INSTR_W'({next_dw, head_dw})
                                          : INSTR_W'(head_dw);
        // in_ready looks only at the registered count: a full buffer stays
        // closed during a pop cycle and reopens on the next one.
        in_ready  = !rst && (count != CW'(DEPTH));
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            out_pc <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            out_pc <= flush_pc & ~PC_W'(3);
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(len_dw);
                out_pc <= out_pc + ((head_len == LEN_2DW) ? PC_W'(8) : PC_W'(4));
            end
            count <= count + (push ? CW'(1) : CW'(0)) - (pop ? len_dw : CW'(0));
        end
    end

`ifdef INSTR_BUF_PERF_EN
    // Counts back-pressure from the decoder; survives flushes on purpose so it
    // measures the whole run.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_dword_buffer.sv
// ----------------------------------------------------------------------------
// tb_instr_dword_buffer
//  Directed scenarios followed by a randomized phase. A queue-based model of
//  the dword stream (exp_q) and the expected PC predicts every output.
// ----------------------------------------------------------------------------
module tb_instr_dword_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [47:0] out_pc;
    logic        flush;
    logic [47:0] flush_pc;
`ifdef INSTR_BUF_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [47:0] exp_pc;
    logic [31:0] exp_stall;

    instr_dword_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .flush     (flush),
        .flush_pc  (flush_pc)
`ifdef INSTR_BUF_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic int ref_len(input logic [31:0] h);
        logic smem, sop1, sopc, sopp, sopk, sop2, lit0, lit1;
        smem = (h[31:26] == 6'h3D);
        sop1 = (h[31:23] == 9'h17D);
        sopc = (h[31:23] == 9'h17E);
        sopp = (h[31:23] == 9'h17F);
        sopk = (h[31:28] == 4'hB) && !sop1 && !sopc && !sopp;
        sop2 = (h[31:30] == 2'b10) && !sopk && !sop1 && !sopc && !sopp;
        lit0 = (h[7:0] == 8'hFF);
        lit1 = (h[15:8] == 8'hFF);
        if (smem) return 2;
        if ((sop2 || sopc) && (lit0 || lit1)) return 2;
        if (sop1 && lit0) return 2;
        return 1;
    endfunction

    function automatic logic m_valid();
        if (exp_q.size() == 0) return 1'b0;
        return exp_q.size() >= ref_len(exp_q[0]);
    endfunction

    function automatic logic [63:0] m_data();
        if (ref_len(exp_q[0]) == 2) return {exp_q[1], exp_q[0]};
        return {32'h0, exp_q[0]};
    endfunction

    function automatic logic [31:0] rand_dword();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 5))
            0: d[31:26] = 6'h3D;                                  // SMEM
            1: begin d[31:30] = 2'b10; d[29] = 1'b0; d[15:8] = 8'hFF; end // SOP2 literal
            2: begin d[31:23] = 9'h17D; d[7:0] = 8'hFF; end        // SOP1 literal
            3: d[31:23] = 9'h17E;                                  // SOPC, maybe literal
            4: d[31:28] = 4'hB;                                    // SOPK family
            default: ;
        endcase
        return d;
    endfunction

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called just after a rising edge; drives inputs, checks outputs mid-cycle,
    // then advances the model across the next rising edge.
    task automatic cyc(input logic r, input logic iv, input logic [31:0] id,
                       input logic ordy, input logic fl, input logic [47:0] fpc);
        logic ev, er;
        int   l;
        rst = r; in_valid = iv; in_data = id; out_ready = ordy;
        flush = fl; flush_pc = fpc;
        #4;
        ev = m_valid();
        er = !r && (exp_q.size() < 8);
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_pc", 64'(out_pc), 64'(exp_pc));
        if (ev) chk("out_data", out_data, m_data());
`ifdef INSTR_BUF_PERF_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
        @(posedge clk);
        if (r) begin
            exp_stall = 0;
        end else if (ev && !ordy && exp_stall != 32'hFFFF_FFFF) begin
            exp_stall = exp_stall + 1;
        end
        if (r) begin
            exp_q.delete();
            exp_pc = 0;
        end else if (fl) begin
            exp_q.delete();
            exp_pc = fpc & ~48'd3;
        end else begin
            if (ev && ordy) begin
                l = ref_len(exp_q[0]);
                for (int k = 0; k < l; k++) void'(exp_q.pop_front());
                exp_pc = exp_pc + 48'(4 * l);
            end
            if (iv && er) exp_q.push_back(id);
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 1'b0, 32'h0, ordy, 1'b0, 48'h0);
    endtask

    task automatic push(input logic [31:0] d, input logic ordy);
        cyc(1'b0, 1'b1, d, ordy, 1'b0, 48'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; flush_pc = '0;
        exp_pc = 0; exp_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset in progress, flush must be ignored
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 48'h4444);
        idle(1'b0);
        chk("reset_out_data", out_data, 64'h0);
        chk("reset_out_pc", 64'(out_pc), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);

        // 1: SOP2 with literal -> one 64-bit instruction
        push(32'h8004FF02, 1'b1);
        push(32'h12345678, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_data", out_data, 64'h12345678_8004FF02);
        chk("t1_pc", 64'(out_pc), 64'h0);
        idle(1'b1);
        chk("t1_next_pc", 64'(out_pc), 64'h8);
        chk("t1_empty", 64'(out_valid), 64'h0);

        // 2: SOP1 without literal, visible the cycle after the push
        push(32'hBE800080, 1'b0);
        chk("t2_valid", 64'(out_valid), 64'h1);
        chk("t2_data", out_data, 64'h00000000_BE800080);
        idle(1'b1);

        // 3: fill with back-pressure, then pop/push across the wrap
        for (int i = 0; i < 8; i++) push(32'h00000100 + 32'(i), 1'b0);
        chk("t3_full", 64'(in_ready), 64'h0);
        push(32'h00000200, 1'b1);   // pop only, in_ready still 0
        chk("t3_reopen", 64'(in_ready), 64'h1);
        push(32'h00000200, 1'b1);   // pop and push together
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("t3_drained", 64'(out_valid), 64'h0);

        // 4: partial SMEM held back for 5 cycles
        push(32'hF4000000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("t4_partial", 64'(out_valid), 64'h0);
        end
        push(32'hCAFEF00D, 1'b0);
        chk("t4_valid", 64'(out_valid), 64'h1);
        chk("t4_data", out_data, 64'hCAFEF00D_F4000000);
        idle(1'b1);

        // 5: flush with a same-cycle push
        push(32'h00000011, 1'b0);
        push(32'h00000022, 1'b0);
        cyc(1'b0, 1'b1, 32'h00000033, 1'b1, 1'b1, 48'h1003);
        chk("t5_valid", 64'(out_valid), 64'h0);
        chk("t5_pc", 64'(out_pc), 64'h1000);
        push(32'hBE800080, 1'b0);
        chk("t5_data", out_data, 64'h00000000_BE800080);
        idle(1'b1);
        chk("t5_next_pc", 64'(out_pc), 64'h1004);

`ifdef INSTR_BUF_PERF_EN
        // 6: stall counter over 10 back-pressured cycles
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 48'h0);
        push(32'h00000044, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("t6_stall", 64'(stall_cycles), 64'd10);
        idle(1'b1);
`endif

        // randomized phase
        for (int n = 0; n < 400; n++) begin
            logic r, iv, ordy, fl;
            r    = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            cyc(r, iv, rand_dword(), ordy, fl, 48'($urandom) << 8 | 48'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
